power_switch_sequencer: RTL and testbench
=========================================

# power_switch_sequencer

Responder for the power manager's sleep request. It receives `sw_ctrl_net` and sequences the switched power domain: clock gating, isolation, and a staged switch-group daisy chain. When the domain is fully off it returns `sw_enable` as the acknowledge, and it drops `sw_enable` again once the domain is fully restored. It sits in `top` between `power_manager` and the switched MIPS domain.

## Interface
Parameters:
- `NSW`, 4: number of power-switch groups; must be ≥1.
- `STAGE_CYC`, 4: cycles between successive switch-group transitions; must be ≥1.
- `ISO_CYC`, 2: cycles that isolation is held before switches turn off, and after isolation release; must be ≥1.
- `SETTLE_CYC`, 8: rail-settle cycles after the last group turns on; must be ≥1.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `sw_ctrl_net` in 1: sleep request; 1 = power down, 0 = power up.
- `sw_enable` out 1: acknowledge; 1 = domain off and isolated.
- `iso_enable` out 1: isolation clamp enable for domain outputs.
- `clk_en` out 1: domain clock enable.
- `sw_on` out NSW: per-group switch enable; 1 = group conducting.
- `pd_state` out 3: current FSM state encoding, for debug.

## Operation
- Four-phase handshake:
  - `sw_ctrl_net` rises, then `sw_enable` rises when the domain is off.
  - `sw_ctrl_net` falls, then `sw_enable` falls when the domain is fully running.
- FSM states: RUN, CLK_OFF, ISO_ON, SW_OFF, OFF, SW_ON, SETTLE, ISO_OFF.
- RUN: all `sw_on` = 1, `iso_enable` = 0, `clk_en` = 1, `sw_enable` = 0. If `sw_ctrl_net` = 1, go to CLK_OFF.
- CLK_OFF: `clk_en` = 0. Lasts 1 cycle, then go to ISO_ON.
- ISO_ON: `iso_enable` = 1. Lasts ISO_CYC cycles, then go to SW_OFF.
- SW_OFF: groups clear highest index first.
  - `sw_on[NSW-1]` clears on entry.
  - One further group clears every STAGE_CYC cycles.
  - STAGE_CYC cycles after `sw_on[0]` clears, go to OFF.
- OFF: `sw_enable` = 1. If `sw_ctrl_net` = 0, go to SW_ON.
- SW_ON: groups set lowest index first.
  - `sw_on[0]` sets on entry.
  - One further group sets every STAGE_CYC cycles.
  - STAGE_CYC cycles after `sw_on[NSW-1]` sets, go to SETTLE.
- SETTLE: lasts SETTLE_CYC cycles, then go to ISO_OFF.
- ISO_OFF: `iso_enable` = 0. Lasts ISO_CYC cycles, then go to RUN. `clk_en` = 1 and `sw_enable` = 0 on the same edge.
- Sequences are non-abortable. The request is sampled only in RUN and OFF.
  - A request drop during power-down completes to OFF, then power-up starts on the next edge.
  - A request rise during power-up completes to RUN, then power-down starts on the next edge.
- All outputs are registered and are pure functions of state, group index and counter. No combinational path exists from `sw_ctrl_net` to any output.
- Reset (any state): the next edge forces RUN values. This includes all `sw_on` = 1 immediately, which is the accepted behaviour. Counter and group index go to 0.
- Timer width is `$clog2` of the largest cycle parameter plus 1. The group index is `$clog2(NSW)` bits, minimum 1. Neither wraps: both stop at their terminal value.

## Timing
Defaults assumed.
- Power-down, with RUN sampling `sw_ctrl_net` = 1 at edge k:
  - `clk_en` falls at k.
  - `iso_enable` rises at k+1.
  - `sw_on[3]`, `[2]`, `[1]`, `[0]` clear at k+3, k+7, k+11, k+15.
  - `sw_enable` rises at k+19.
  - General form: group NSW-1-i clears at k+1+ISO_CYC+i·STAGE_CYC; ack at k+1+ISO_CYC+NSW·STAGE_CYC.
- Power-up, with OFF sampling `sw_ctrl_net` = 0 at edge m:
  - `sw_on[0..3]` set at m, m+4, m+8, m+12.
  - SETTLE spans m+16 to m+24.
  - `iso_enable` falls at m+24.
  - `clk_en` rises and `sw_enable` falls at m+26.
- Invariants:
  - `iso_enable` = 1 whenever any `sw_on` bit is 0.
  - `clk_en` = 0 whenever `iso_enable` = 1.

## Structure
- `power_pkg` holds:
  - the `pwr_state_t` enum (3-bit encodings: RUN=0, CLK_OFF=1, ISO_ON=2, SW_OFF=3, OFF=4, SW_ON=5, SETTLE=6, ISO_OFF=7);
  - default parameter constants.
- One sub-module, `pwr_timer`: a loadable down-counter with load value, load strobe and a `done` flag, using synchronous reset. It is shared by all timed states.
- The top FSM owns the group index and the `sw_on` register.

## Test plan
- Reset asserted for 2 cycles -> `sw_on` = 4'b1111, `iso_enable` = 0, `clk_en` = 1, `sw_enable` = 0, `pd_state` = 0.
- Power-down: `sw_ctrl_net` = 1 held from edge k -> `clk_en` = 0 at k, `iso_enable` = 1 at k+1, `sw_on` = 0111/0011/0001/0000 at k+3/k+7/k+11/k+15, `sw_enable` = 1 at k+19.
- Power-up from OFF: drop `sw_ctrl_net` at edge m -> `sw_on` = 0001/0011/0111/1111 at m/m+4/m+8/m+12, `iso_enable` = 0 at m+24, `sw_enable` = 0 and `clk_en` = 1 at m+26.
- Request drops at k+5 during power-down -> OFF reached at k+19 unchanged, `sw_on[0]` = 1 at k+20, RUN at k+46.
- Reset asserted at k+9 mid power-down -> on the next edge all outputs take RUN values; a held request restarts power-down on the following edge.
- Invariant checker active in all tests: any `sw_on` bit = 0 implies `iso_enable` = 1; `iso_enable` = 1 implies `clk_en` = 0.

Source files
------------

// File: rtl/power_pkg.sv
// rtl/power_pkg.sv - shared state encoding and defaults for the switched-domain sequencer
package power_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_CLK_OFF = 3'd1,
        ST_ISO_ON  = 3'd2,
        ST_SW_OFF  = 3'd3,
        ST_OFF     = 3'd4,
        ST_SW_ON   = 3'd5,
        ST_SETTLE  = 3'd6,
        ST_ISO_OFF = 3'd7
    } pwr_state_t;

    localparam int DEF_NSW        = 4;
    localparam int DEF_STAGE_CYC  = 4;
    localparam int DEF_ISO_CYC    = 2;
    localparam int DEF_SETTLE_CYC = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pwr_timer.sv
// rtl/pwr_timer.sv - loadable down-counter shared by every timed sequencer state
module pwr_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Saturates at zero so a stale done never wraps into a long count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/power_switch_sequencer.sv
// rtl/power_switch_sequencer.sv - sleep-request responder: clock gate, isolate, stage power switches
module power_switch_sequencer
    import power_pkg::*;
#(
    parameter int NSW        = DEF_NSW,
    parameter int STAGE_CYC  = DEF_STAGE_CYC,
    parameter int ISO_CYC    = DEF_ISO_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sw_ctrl_net,
    output logic           sw_enable,
    output logic           iso_enable,
    output logic           clk_en,
    output logic [NSW-1:0] sw_on,
    output logic [2:0]     pd_state
);

    localparam int TW = $clog2(max3(STAGE_CYC, ISO_CYC, SETTLE_CYC)) + 1;
    localparam int GW = (NSW > 1) ? $clog2(NSW) : 1;

    // Timer loads N-1 so that a state dwells exactly N cycles.
    localparam logic [TW-1:0] STAGE_LD  = TW'(STAGE_CYC - 1);
    localparam logic [TW-1:0] ISO_LD    = TW'(ISO_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0] LAST_GRP  = GW'(NSW - 1);

    pwr_state_t     r_state, w_state_nxt;
    logic [GW-1:0]  r_grp, w_grp_nxt;
    logic           w_load;
    logic [TW-1:0]  w_load_val;
    logic           w_done;

    logic           r_sw_enable, r_iso_enable, r_clk_en;
    logic [NSW-1:0] r_sw_on;
    logic           w_sw_enable_nxt, w_iso_enable_nxt, w_clk_en_nxt;
    logic [NSW-1:0] w_sw_on_nxt;

    pwr_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_load      = 1'b0;
        w_load_val  = '0;
        unique case (r_state)
            ST_RUN: begin
                if (sw_ctrl_net) w_state_nxt = ST_CLK_OFF;
            end
            ST_CLK_OFF: begin
                w_state_nxt = ST_ISO_ON;
                w_load      = 1'b1;
                w_load_val  = ISO_LD;
            end
            ST_ISO_ON: begin
                if (w_done) begin
                    w_state_nxt = ST_SW_OFF;
                    w_grp_nxt   = '0;
                    w_load      = 1'b1;
                    w_load_val  = STAGE_LD;
                end
            end
            ST_SW_OFF: begin
                if (w_done) begin
                    if (r_grp == LAST_GRP) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_grp_nxt  = r_grp + 1'b1;
                        w_load     = 1'b1;
                        w_load_val = STAGE_LD;
                    end
                end
            end
            ST_OFF: begin
                if (!sw_ctrl_net) begin
                    w_state_nxt = ST_SW_ON;
                    w_grp_nxt   = '0;
                    w_load      = 1'b1;
                    w_load_val  = STAGE_LD;
                end
            end
            ST_SW_ON: begin
                if (w_done) begin
                    w_load = 1'b1;
                    if (r_grp == LAST_GRP) begin
                        w_state_nxt = ST_SETTLE;
                        w_load_val  = SETTLE_LD;
                    end else begin
                        w_grp_nxt  = r_grp + 1'b1;
                        w_load_val = STAGE_LD;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_done) begin
                    w_state_nxt = ST_ISO_OFF;
                    w_load      = 1'b1;
                    w_load_val  = ISO_LD;
                end
            end
            ST_ISO_OFF: begin
                if (w_done) begin
                    w_state_nxt = ST_RUN;
                    w_grp_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_grp_nxt   = '0;
            end
        endcase
    end

    // Output values are decoded from the upcoming state so they register on the transition edge.
    always_comb begin
        w_clk_en_nxt     = (w_state_nxt == ST_RUN);
        w_iso_enable_nxt = (w_state_nxt == ST_ISO_ON) || (w_state_nxt == ST_SW_OFF) ||
                           (w_state_nxt == ST_OFF)    || (w_state_nxt == ST_SW_ON)  ||
                           (w_state_nxt == ST_SETTLE);
        w_sw_enable_nxt  = (w_state_nxt == ST_OFF)    || (w_state_nxt == ST_SW_ON)  ||
                           (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_ISO_OFF);
        w_sw_on_nxt      = '1;
        for (int j = 0; j < NSW; j++) begin
            if (w_state_nxt == ST_SW_OFF)
                w_sw_on_nxt[j] = (j < (NSW - 1 - int'(w_grp_nxt)));
            else if (w_state_nxt == ST_OFF)
                w_sw_on_nxt[j] = 1'b0;
            else if (w_state_nxt == ST_SW_ON)
                w_sw_on_nxt[j] = (j <= int'(w_grp_nxt));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_grp        <= '0;
            r_sw_on      <= '1;
            r_iso_enable <= 1'b0;
            r_clk_en     <= 1'b1;
            r_sw_enable  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grp        <= w_grp_nxt;
            r_sw_on      <= w_sw_on_nxt;
            r_iso_enable <= w_iso_enable_nxt;
            r_clk_en     <= w_clk_en_nxt;
            r_sw_enable  <= w_sw_enable_nxt;
        end
    end

    assign sw_on      = r_sw_on;
    assign iso_enable = r_iso_enable;
    assign clk_en     = r_clk_en;
    assign sw_enable  = r_sw_enable;
    assign pd_state   = r_state;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// tb/tb_power_switch_sequencer.sv - randomized bench against a timeline model of the sequencer
module tb_power_switch_sequencer;

    localparam int NSW      = 4;
    localparam int STAGE    = 4;
    localparam int ISO      = 2;
    localparam int SETTLE   = 8;
    localparam int DOWN_LEN = 1 + ISO + NSW * STAGE;
    localparam int UP_LEN   = NSW * STAGE + SETTLE + ISO;

    logic           clk = 1'b0;
    logic           reset;
    logic           sw_ctrl_net;
    logic           sw_enable;
    logic           iso_enable;
    logic           clk_en;
    logic [NSW-1:0] sw_on;
    logic [2:0]     pd_state;

    always #5 clk = ~clk;

    power_switch_sequencer #(
        .NSW        (NSW),
        .STAGE_CYC  (STAGE),
        .ISO_CYC    (ISO),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_ctrl_net (sw_ctrl_net),
        .sw_enable   (sw_enable),
        .iso_enable  (iso_enable),
        .clk_en      (clk_en),
        .sw_on       (sw_on),
        .pd_state    (pd_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Domain is modelled as a timeline: time since the sequence started decides every output.
    typedef enum {M_RUN, M_DOWN, M_OFF, M_UP} mode_t;
    mode_t m_mode  = M_RUN;
    int    m_t     = 0;
    bit    m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode  = M_RUN;
            m_t     = 0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_RUN:  if (sw_ctrl_net) begin m_mode = M_DOWN; m_t = 0; end
                M_DOWN: begin m_t++; if (m_t == DOWN_LEN) m_mode = M_OFF; end
                M_OFF:  if (!sw_ctrl_net) begin m_mode = M_UP; m_t = 0; end
                M_UP:   begin m_t++; if (m_t == UP_LEN) m_mode = M_RUN; end
            endcase
        end
    end

    int e_sw, e_iso, e_clk, e_ack, e_st, n_grp;

    always @(negedge clk) begin
        if (m_valid) begin
            case (m_mode)
                M_RUN: begin
                    e_sw = (1 << NSW) - 1; e_iso = 0; e_clk = 1; e_ack = 0; e_st = 0;
                end
                M_DOWN: begin
                    n_grp = (m_t < 1 + ISO) ? 0 : (m_t - 1 - ISO) / STAGE + 1;
                    if (n_grp > NSW) n_grp = NSW;
                    e_sw  = (1 << (NSW - n_grp)) - 1;
                    e_iso = (m_t >= 1) ? 1 : 0;
                    e_clk = 0; e_ack = 0;
                    e_st  = (m_t == 0) ? 1 : (m_t < 1 + ISO) ? 2 : 3;
                end
                M_OFF: begin
                    e_sw = 0; e_iso = 1; e_clk = 0; e_ack = 1; e_st = 4;
                end
                default: begin
                    n_grp = m_t / STAGE + 1;
                    if (n_grp > NSW) n_grp = NSW;
                    e_sw  = (1 << n_grp) - 1;
                    e_iso = (m_t < NSW * STAGE + SETTLE) ? 1 : 0;
                    e_clk = 0; e_ack = 1;
                    e_st  = (m_t < NSW * STAGE) ? 5 : (m_t < NSW * STAGE + SETTLE) ? 6 : 7;
                end
            endcase
            check("sw_on",      32'(sw_on),      32'(e_sw));
            check("iso_enable", 32'(iso_enable), 32'(e_iso));
            check("clk_en",     32'(clk_en),     32'(e_clk));
            check("sw_enable",  32'(sw_enable),  32'(e_ack));
            check("pd_state",   32'(pd_state),   32'(e_st));
            check("inv_iso",    32'((sw_on != '1) && !iso_enable), 32'(0));
            check("inv_clk",    32'(iso_enable && clk_en),         32'(0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        sw_ctrl_net = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(3);

        // full power-down, linger in OFF, full power-up
        sw_ctrl_net = 1'b1;
        cyc(DOWN_LEN + 6);
        sw_ctrl_net = 1'b0;
        cyc(UP_LEN + 5);

        // request withdrawn part way through power-down
        sw_ctrl_net = 1'b1;
        cyc(6);
        sw_ctrl_net = 1'b0;
        cyc(DOWN_LEN + UP_LEN + 6);

        // reset mid power-down with the request still held
        sw_ctrl_net = 1'b1;
        cyc(9);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(DOWN_LEN + 4);
        sw_ctrl_net = 1'b0;
        cyc(UP_LEN + 4);

        // request re-raised during power-up
        sw_ctrl_net = 1'b1;
        cyc(DOWN_LEN + 2);
        sw_ctrl_net = 1'b0;
        cyc(7);
        sw_ctrl_net = 1'b1;
        cyc(UP_LEN + DOWN_LEN + 4);
        sw_ctrl_net = 1'b0;
        cyc(UP_LEN + 4);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) sw_ctrl_net = ~sw_ctrl_net;
            reset = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
